// File: rtl/fft4_out_serializer_if.sv
// Beat-in / sample-out bus for the FFT4 output serializer.
// master = upstream/sink side, slave = the serializer itself.
interface fft4_out_serializer_if #(
  parameter int DATA_WIDTH  = 27,
  parameter int INDEX_WIDTH = 11,
  parameter int DEPTH       = 4
);
  logic                          in_valid;
  logic [INDEX_WIDTH-1:0]        in_index;
  logic signed [DATA_WIDTH-1:0]  y0_r, y0_i, y1_r, y1_i;
  logic signed [DATA_WIDTH-1:0]  y2_r, y2_i, y3_r, y3_i;
  logic                          flush;
  logic                          out_ready;
  logic                          out_valid;
  logic signed [DATA_WIDTH-1:0]  out_r, out_i;
  logic [INDEX_WIDTH+1:0]        out_index;
  logic                          out_last;
  logic [$clog2(DEPTH):0]        level;
  logic                          overflow;

  modport master (
    output in_valid, in_index, y0_r, y0_i, y1_r, y1_i, y2_r, y2_i, y3_r, y3_i,
    output flush, out_ready,
    input  out_valid, out_r, out_i, out_index, out_last, level, overflow
  );

  modport slave (
    input  in_valid, in_index, y0_r, y0_i, y1_r, y1_i, y2_r, y2_i, y3_r, y3_i,
    input  flush, out_ready,
    output out_valid, out_r, out_i, out_index, out_last, level, overflow
  );
endinterface

// File: rtl/fft4_out_serializer.sv
// FFT4 output serializer: buffers whole 4-sample beats from the parallel
// stage and streams them out one complex sample per cycle. Upstream cannot
// be stalled, so a beat arriving into a full buffer is dropped and flagged.
module fft4_out_serializer #(
  parameter int DATA_WIDTH  = 27,
  parameter int INDEX_WIDTH = 11,
  parameter int DEPTH       = 4
) (
  input logic                   clk,
  input logic                   rst_n,
  fft4_out_serializer_if.slave  bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic signed [DATA_WIDTH-1:0] mem_r [DEPTH][4];
  logic signed [DATA_WIDTH-1:0] mem_i [DEPTH][4];
  logic [INDEX_WIDTH-1:0]       mem_idx [DEPTH];

  logic [PTR_W-1:0] wptr, rptr;
  logic [CNT_W-1:0] count;
  logic [1:0]       k;
  logic             overflow_q;

  logic full, not_empty, xfer, pop_beat, push, drop;

  // Handshake decode: a slot freed by finishing the head beat can be reused
  // by a beat arriving on the same edge, so a full buffer never drops then.
  always_comb begin
    full      = (count == CNT_W'(DEPTH));
    not_empty = (count != '0);
    xfer      = not_empty & bus.out_ready;
    pop_beat  = xfer & (k == 2'd3);
    push      = bus.in_valid & (~full | pop_beat);
    drop      = bus.in_valid & full & ~pop_beat;
  end

  // Beat storage; contents are don't-care until counted, so no reset needed.
  always_ff @(posedge clk) begin
    if (push && !bus.flush) begin
      mem_r[wptr][0] <= bus.y0_r;
      mem_r[wptr][1] <= bus.y1_r;
      mem_r[wptr][2] <= bus.y2_r;
      mem_r[wptr][3] <= bus.y3_r;
      mem_i[wptr][0] <= bus.y0_i;
      mem_i[wptr][1] <= bus.y1_i;
      mem_i[wptr][2] <= bus.y2_i;
      mem_i[wptr][3] <= bus.y3_i;
      mem_idx[wptr]  <= bus.in_index;
    end
  end

  // Pointers, beat count, sample sub-counter and sticky overflow; flush
  // overrides any same-cycle push or pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      k          <= '0;
      overflow_q <= 1'b0;
    end else if (bus.flush) begin
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      k          <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        wptr <= wptr + 1'b1;
      end
      if (xfer) begin
        k <= k + 2'd1;
      end
      if (pop_beat) begin
        rptr <= rptr + 1'b1;
      end
      case ({push, pop_beat})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Output view of the head sample, forced to zero when nothing is stored.
  always_comb begin
    bus.out_valid = not_empty;
    bus.out_r     = '0;
    bus.out_i     = '0;
    bus.out_index = '0;
    bus.out_last  = 1'b0;
    if (not_empty) begin
      bus.out_r     = mem_r[rptr][k];
      bus.out_i     = mem_i[rptr][k];
      bus.out_index = {mem_idx[rptr], k};
      bus.out_last  = (k == 2'd3);
    end
    bus.level    = count;
    bus.overflow = overflow_q;
  end

endmodule

// File: tb/tb_fft4_out_serializer.sv
// Directed bench for fft4_out_serializer with a sample-level scoreboard.
module tb_fft4_out_serializer;

  localparam int DW    = 27;
  localparam int IW    = 11;
  localparam int DEPTH = 4;

  typedef struct {
    logic signed [DW-1:0] r;
    logic signed [DW-1:0] i;
    logic [IW+1:0]        idx;
    logic                 last;
  } sample_t;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  bit   modelOvf = 1'b0;
  sample_t sb[$];

  fft4_out_serializer_if #(.DATA_WIDTH(DW), .INDEX_WIDTH(IW), .DEPTH(DEPTH)) bus ();

  fft4_out_serializer #(.DATA_WIDTH(DW), .INDEX_WIDTH(IW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [IW-1:0] idx,
                               input logic signed [DW-1:0] r0,
                               input logic signed [DW-1:0] i0,
                               input logic rdy, input logic fl);
    bus.in_valid  = v;
    bus.in_index  = idx;
    bus.y0_r      = r0;
    bus.y1_r      = r0 + 27'sd1;
    bus.y2_r      = r0 + 27'sd2;
    bus.y3_r      = r0 + 27'sd3;
    bus.y0_i      = i0;
    bus.y1_i      = i0 - 27'sd1;
    bus.y2_i      = i0 - 27'sd2;
    bus.y3_i      = i0 - 27'sd3;
    bus.out_ready = rdy;
    bus.flush     = fl;
  endtask

  task automatic pushModelBeat();
    sample_t s;
    logic signed [DW-1:0] rr [4];
    logic signed [DW-1:0] ii [4];
    rr[0] = bus.y0_r; rr[1] = bus.y1_r; rr[2] = bus.y2_r; rr[3] = bus.y3_r;
    ii[0] = bus.y0_i; ii[1] = bus.y1_i; ii[2] = bus.y2_i; ii[3] = bus.y3_i;
    for (int n = 0; n < 4; n++) begin
      s.r    = rr[n];
      s.i    = ii[n];
      s.idx  = {bus.in_index, 2'(n)};
      s.last = (n == 3);
      sb.push_back(s);
    end
  endtask

  // Compare current outputs with the scoreboard head, advance the model
  // with the inputs about to be sampled, then cross one clock edge.
  task automatic step();
    sample_t head;
    bit      haveHead;
    bit      popBeat;
    int      beats;
    haveHead = (sb.size() != 0);
    if (haveHead) head = sb[0];
    else begin
      head.r = '0; head.i = '0; head.idx = '0; head.last = 1'b0;
    end
    beats = (sb.size() + 3) / 4;
    checkOutput("out_valid", 32'(bus.out_valid), 32'(haveHead));
    checkOutput("out_r", 32'(bus.out_r), 32'(head.r));
    checkOutput("out_i", 32'(bus.out_i), 32'(head.i));
    checkOutput("out_index", 32'(bus.out_index), 32'(head.idx));
    checkOutput("out_last", 32'(bus.out_last), 32'(head.last));
    checkOutput("level", 32'(bus.level), 32'(beats));
    checkOutput("overflow", 32'(bus.overflow), 32'(modelOvf));
    if (rst_n) begin
      if (bus.flush) begin
        sb.delete();
        modelOvf = 1'b0;
      end else begin
        popBeat = 1'b0;
        if (haveHead && bus.out_ready) begin
          popBeat = head.last;
          void'(sb.pop_front());
        end
        if (bus.in_valid) begin
          if (beats < DEPTH || popBeat) pushModelBeat();
          else modelOvf = 1'b1;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input logic rdy, input int n);
    applyStimulus(1'b0, '0, '0, '0, rdy, 1'b0);
    repeat (n) step();
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    // Reset state
    step();
    rst_n = 1'b1;
    step();

    // Single beat, full-rate drain
    $display("[TB] single beat");
    applyStimulus(1'b1, 11'h005, 27'sd1, -27'sd1, 1'b1, 1'b0);
    step();
    checkOutput("first_index", 32'(bus.out_index), 32'h014);
    checkOutput("first_r", 32'(bus.out_r), 32'(27'sd1));
    checkOutput("first_i", 32'(bus.out_i), 32'(-27'sd1));
    idle(1'b1, 5);

    // Overflow with five back-to-back beats and a blocked sink
    $display("[TB] overflow");
    for (int b = 0; b < 5; b++) begin
      applyStimulus(1'b1, 11'(11'h100 + b), 27'($urandom), 27'($urandom), 1'b0, 1'b0);
      step();
    end
    idle(1'b0, 1);
    checkOutput("ovf_level", 32'(bus.level), 32'd4);
    checkOutput("ovf_flag", 32'(bus.overflow), 32'd1);
    idle(1'b1, 17);
    applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b1);
    step();
    idle(1'b0, 1);

    // Stall in the middle of a beat
    $display("[TB] stall");
    applyStimulus(1'b1, 11'h2A5, -27'sd1000, 27'sh2AAAAAA, 1'b0, 1'b0);
    step();
    idle(1'b1, 1);
    idle(1'b0, 2);
    idle(1'b1, 4);

    // Full buffer, head finishing while a new beat arrives
    $display("[TB] full with pop");
    for (int b = 0; b < 4; b++) begin
      applyStimulus(1'b1, 11'(11'h300 + b), 27'($urandom), 27'($urandom), 1'b0, 1'b0);
      step();
    end
    idle(1'b1, 3);
    applyStimulus(1'b1, 11'h3FE, 27'sh3FFFFFF, 27'sh4000000, 1'b1, 1'b0);
    step();
    idle(1'b0, 1);
    checkOutput("full_level", 32'(bus.level), 32'd4);
    checkOutput("full_ovf", 32'(bus.overflow), 32'd0);
    idle(1'b1, 17);

    // Flush with partial head and overflow set; flush beats same-cycle push
    $display("[TB] flush");
    for (int b = 0; b < 5; b++) begin
      applyStimulus(1'b1, 11'(11'h400 + b), 27'($urandom), 27'($urandom), 1'b0, 1'b0);
      step();
    end
    idle(1'b1, 6);
    checkOutput("preflush_level", 32'(bus.level), 32'd3);
    checkOutput("preflush_k", 32'(bus.out_index[1:0]), 32'd2);
    applyStimulus(1'b1, 11'h555, 27'sd7, 27'sd9, 1'b1, 1'b1);
    step();
    checkOutput("postflush_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("postflush_level", 32'(bus.level), 32'd0);
    checkOutput("postflush_ovf", 32'(bus.overflow), 32'd0);
    applyStimulus(1'b1, 11'h0C3, 27'sd55, -27'sd66, 1'b1, 1'b0);
    step();
    checkOutput("postflush_k", 32'(bus.out_index), 32'({11'h0C3, 2'b00}));
    idle(1'b1, 5);

    // Asynchronous reset in the middle of a beat
    $display("[TB] reset mid-beat");
    applyStimulus(1'b1, 11'h033, 27'sd123, 27'sd456, 1'b1, 1'b0);
    step();
    idle(1'b1, 1);
    checkOutput("pre_reset_k", 32'(bus.out_index[1:0]), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_r", 32'(bus.out_r), 32'd0);
    checkOutput("rst_index", 32'(bus.out_index), 32'd0);
    checkOutput("rst_level", 32'(bus.level), 32'd0);
    sb.delete();
    modelOvf = 1'b0;
    @(negedge clk);
    idle(1'b1, 2);
    rst_n = 1'b1;
    idle(1'b1, 1);
    applyStimulus(1'b1, 11'h7FF, -27'sd5, 27'sd5, 1'b1, 1'b0);
    step();
    checkOutput("rst_new_index", 32'(bus.out_index), 32'h1FFC);
    idle(1'b1, 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fft4_out_serializer.md
# fft4_out_serializer

Output-side stage placed directly downstream of the parallel twiddle-multiply FFT4 stage. Accepts one beat of four complex results (y0..y3) plus the beat's 11-bit index each time the upstream `ready` strobe fires. Buffers up to DEPTH beats and streams them out one complex sample per cycle over a valid/ready handshake. Upstream has no backpressure, so overflow is detected and flagged rather than prevented.

## Interface
- DATA_WIDTH, 27, width of each real/imag component
- INDEX_WIDTH, 11, width of the beat index
- DEPTH, 4, beat FIFO depth in beats (power of two, ≥2)
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- in_valid  input  1  beat strobe (driven by upstream `ready`)
- in_index  input  INDEX_WIDTH  beat index (upstream `index`)
- y0_r, y0_i, y1_r, y1_i, y2_r, y2_i, y3_r, y3_i  input  DATA_WIDTH each  beat samples, signed
- flush  input  1  synchronous clear of FIFO, sub-counter and overflow
- out_ready  input  1  sink accepts current sample
- out_valid  output  1  sample available
- out_r, out_i  output  DATA_WIDTH each  current sample, signed
- out_index  output  INDEX_WIDTH+2  {beat index, sample number k[1:0]}
- out_last  output  1  high when k==3 (last sample of beat)
- level  output  $clog2(DEPTH)+1  beats stored, including the partially drained head
- overflow  output  1  sticky; a beat was dropped

## Operation
- Storage: DEPTH entries, each holding 8 components plus index. Write pointer, read pointer, count, and 2-bit sub-counter k are all registers.
- Push: in_valid=1 and (count<DEPTH or pop_beat this cycle) → write entry at wptr, wptr+1 (wraps modulo DEPTH).
- Drop: in_valid=1, count==DEPTH, no pop_beat → beat discarded, overflow←1, no pointer change.
- Output: out_valid = (count!=0). out_r/out_i select head entry sample k. out_index = {head index, k}. out_last = out_valid & (k==3).
- When empty: out_r, out_i, out_index, and out_last read 0.
- Transfer: out_valid & out_ready → k+1. If k==3 (pop_beat), k←0, rptr+1 (wraps), count−1.
- Count update when push and pop_beat occur in the same cycle: unchanged.
- out_valid low: out_ready ignored, k holds.
- Stall: out_ready=0 holds k and all outputs stable; out_valid never drops while count!=0.
- flush=1: count, wptr, rptr, k, and overflow ← 0. flush has priority over a same-cycle push and pop; both are ignored.
- overflow clears only on reset or flush.
- No arithmetic on data; samples pass through bit-exact.

## Timing
- Reset values: out_valid 0, out_r 0, out_i 0, out_index 0, out_last 0, level 0, overflow 0. Pointers and k are 0. Storage content is don't-care.
- Reset asserted mid-stream: all state clears immediately (asynchronous). The partially drained beat is lost. The first beat after release starts at k=0.
- Latency: beat sampled at edge t into an empty FIFO → out_valid=1 and sample 0 visible after edge t, before edge t+1.
- Throughput: 4 cycles per beat at out_ready=1. Upstream beats closer than 4 cycles apart consume FIFO slack.
- level updates on the same edge as the push or pop that changes it.
- No combinational path from in_* to out_*. out_* depend only on registers.

## Test plan
- Single beat, index 0x005, y0_r..y3_r = 1,2,3,4 and y0_i..y3_i = −1,−2,−3,−4, out_ready=1 → four consecutive cycles out (1,−1,idx 0x014), (2,−2,0x015), (3,−3,0x016), (4,−4,0x017); out_last only on the 4th; then out_valid=0 and level=0.
- out_ready=0, five beats on consecutive cycles → level=4 after the 4th; 5th dropped, overflow=1. Release out_ready → 16 samples from beats 1–4 in order, none from beat 5.
- Stall mid-beat: out_ready toggles 1,0,0,1 during beat → k advances only on ready cycles; out_r/out_i/out_index held stable through stall; no sample repeated or skipped.
- FIFO full with head at k=3 and out_ready=1, in_valid=1 same cycle → beat accepted, overflow stays 0, level stays 4.
- flush asserted with level=3, k=2, overflow=1 → next cycle out_valid=0, level=0, overflow=0; next beat emerges with out_index low bits 0.
- rst_n pulsed low mid-beat (k=1) → outputs 0 immediately. After release, a new beat with index 0x7FF yields out_index 0x1FFC..0x1FFF.
